// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters.
// Registered lookup port, single resolution/update port, per-set victim pointer.
module btb_assoc #(
  parameter int WAYS       = 2,
  parameter int INDEX_BITS = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Flush_IN,
  input  logic [31:0] Instr_Addr_IN,
  input  logic        Is_Branch_IN,
  input  logic        Resolution_IN,
  input  logic [31:0] Branch_addr_IN,
  input  logic        Branch_taken_IN,
  input  logic [31:0] Branch_resolved_addr_IN,
  output logic [31:0] Addr_OUT,
  output logic        Valid_OUT,
  output logic        Hit_OUT,
  output logic [1:0]  Hit_Way_OUT
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WW       = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [WW-1:0]       ptr_q   [SETS];
  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [31:0]         tgt_q   [SETS][WAYS];
  logic [1:0]          ctr_q   [SETS][WAYS];

  logic [31:0] addr_q, addr_d;
  logic        vout_q, vout_d;
  logic        hit_q, hit_d;
  logic [1:0]  hway_q, hway_d;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic [2:0]            lk_cnt, up_cnt;
  logic [WW-1:0]         lk_way, up_way;
  logic [WW-1:0]         free_way;
  logic                  free_ok;

  logic          upd_en;
  logic          alloc;
  logic          ctr_we;
  logic          tgt_we;
  logic          ptr_we;
  logic [WW-1:0] wr_way;
  logic [1:0]    ctr_nxt;
  logic [WW-1:0] ptr_nxt;

  logic unused_ok;
  assign unused_ok = ^{Instr_Addr_IN[1:0], Branch_addr_IN[1:0]};

  assign lk_idx = Instr_Addr_IN[INDEX_BITS+1:2];
  assign lk_tag = Instr_Addr_IN[31:INDEX_BITS+2];
  assign up_idx = Branch_addr_IN[INDEX_BITS+1:2];
  assign up_tag = Branch_addr_IN[31:INDEX_BITS+2];

  // Tag match on the lookup set; a hit needs exactly one matching way
  always_comb begin
    lk_cnt = '0;
    lk_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[lk_idx][i] && tag_q[lk_idx][i] == lk_tag) begin
        lk_cnt = lk_cnt + 3'd1;
        lk_way = WW'(i);
      end
    end
  end

  // Tag match and first free way on the update set
  always_comb begin
    up_cnt   = '0;
    up_way   = '0;
    free_ok  = 1'b0;
    free_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[up_idx][i] && tag_q[up_idx][i] == up_tag) begin
        up_cnt = up_cnt + 3'd1;
        up_way = WW'(i);
      end
      if (!valid_q[up_idx][i] && !free_ok) begin
        free_ok  = 1'b1;
        free_way = WW'(i);
      end
    end
  end

  // Next lookup result, computed from pre-edge table contents
  always_comb begin
    addr_d = '0;
    vout_d = 1'b0;
    hit_d  = 1'b0;
    hway_d = '0;
    if (!RESET && !Flush_IN && Is_Branch_IN && lk_cnt == 3'd1) begin
      hit_d  = 1'b1;
      hway_d = 2'(lk_way);
      if (ctr_q[lk_idx][lk_way] >= 2'd2) begin
        vout_d = 1'b1;
        addr_d = tgt_q[lk_idx][lk_way];
      end
    end
  end

  // Resolution: train a hit entry or allocate on a taken miss
  always_comb begin
    upd_en  = Resolution_IN && !RESET && !Flush_IN;
    alloc   = 1'b0;
    ctr_we  = 1'b0;
    tgt_we  = 1'b0;
    ptr_we  = 1'b0;
    wr_way  = '0;
    ctr_nxt = '0;
    ptr_nxt = ptr_q[up_idx];
    if (upd_en && up_cnt == 3'd1) begin
      wr_way = up_way;
      ctr_we = 1'b1;
      tgt_we = Branch_taken_IN;
      if (Branch_taken_IN)
        ctr_nxt = (ctr_q[up_idx][up_way] == 2'd3) ? 2'd3
                : ctr_q[up_idx][up_way] + 2'd1;
      else
        ctr_nxt = (ctr_q[up_idx][up_way] == 2'd0) ? 2'd0
                : ctr_q[up_idx][up_way] - 2'd1;
    end else if (upd_en && Branch_taken_IN) begin
      alloc   = 1'b1;
      ctr_we  = 1'b1;
      tgt_we  = 1'b1;
      ctr_nxt = 2'd2;
      if (free_ok) begin
        wr_way = free_way;
      end else begin
        wr_way = ptr_q[up_idx];
        if (WAYS > 1) begin
          ptr_we  = 1'b1;
          ptr_nxt = ptr_q[up_idx] + WW'(1);
        end
      end
    end
  end

  // Valid bits and victim pointers: cleared by reset or flush
  always_ff @(posedge CLK) begin
    if (RESET || Flush_IN) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      if (alloc)
        valid_q[up_idx][wr_way] <= 1'b1;
      if (ptr_we)
        ptr_q[up_idx] <= ptr_nxt;
    end
  end

  // Entry payload storage, never reset
  always_ff @(posedge CLK) begin
    if (alloc)
      tag_q[up_idx][wr_way] <= up_tag;
    if (tgt_we)
      tgt_q[up_idx][wr_way] <= Branch_resolved_addr_IN;
    if (ctr_we)
      ctr_q[up_idx][wr_way] <= ctr_nxt;
  end

  // Registered lookup outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q <= '0;
      vout_q <= 1'b0;
      hit_q  <= 1'b0;
      hway_q <= '0;
    end else begin
      addr_q <= addr_d;
      vout_q <= vout_d;
      hit_q  <= hit_d;
      hway_q <= hway_d;
    end
  end

  assign Addr_OUT    = addr_q;
  assign Valid_OUT   = vout_q;
  assign Hit_OUT     = hit_q;
  assign Hit_Way_OUT = hway_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc (WAYS=2, INDEX_BITS=10): directed scenarios
// followed by random traffic against a behavioural table model.
module tb_btb_assoc;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Flush_IN;
  logic [31:0] Instr_Addr_IN;
  logic        Is_Branch_IN;
  logic        Resolution_IN;
  logic [31:0] Branch_addr_IN;
  logic        Branch_taken_IN;
  logic [31:0] Branch_resolved_addr_IN;
  logic [31:0] Addr_OUT;
  logic        Valid_OUT;
  logic        Hit_OUT;
  logic [1:0]  Hit_Way_OUT;

  int errors = 0;
  int checks = 0;

  btb_assoc dut (
    .CLK                     (CLK),
    .RESET                   (RESET),
    .Flush_IN                (Flush_IN),
    .Instr_Addr_IN           (Instr_Addr_IN),
    .Is_Branch_IN            (Is_Branch_IN),
    .Resolution_IN           (Resolution_IN),
    .Branch_addr_IN          (Branch_addr_IN),
    .Branch_taken_IN         (Branch_taken_IN),
    .Branch_resolved_addr_IN (Branch_resolved_addr_IN),
    .Addr_OUT                (Addr_OUT),
    .Valid_OUT               (Valid_OUT),
    .Hit_OUT                 (Hit_OUT),
    .Hit_Way_OUT             (Hit_Way_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        v;
    bit [19:0] tag;
    bit [31:0] tgt;
    int        ctr;
  } ent_t;

  ent_t m    [1024][2];
  int   mptr [1024];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_find(input bit [31:0] pc, output int w);
    int s = int'(pc[11:2]);
    int n = 0;
    w = 0;
    for (int i = 0; i < 2; i++)
      if (m[s][i].v && m[s][i].tag == pc[31:12]) begin
        n++;
        w = i;
      end
    return n == 1;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 1024; s++) begin
      mptr[s] = 0;
      for (int i = 0; i < 2; i++) m[s][i].v = 1'b0;
    end
  endfunction

  function automatic void m_update(input bit [31:0] pc, input bit tk,
                                   input bit [31:0] tgt);
    int s = int'(pc[11:2]);
    int w;
    if (m_find(pc, w)) begin
      if (tk) begin
        m[s][w].ctr = (m[s][w].ctr + 1 > 3) ? 3 : m[s][w].ctr + 1;
        m[s][w].tgt = tgt;
      end else begin
        m[s][w].ctr = (m[s][w].ctr - 1 < 0) ? 0 : m[s][w].ctr - 1;
      end
    end else if (tk) begin
      w = -1;
      for (int i = 0; i < 2; i++)
        if (!m[s][i].v && w < 0) w = i;
      if (w < 0) begin
        w = mptr[s];
        mptr[s] = (mptr[s] + 1) % 2;
      end
      m[s][w].v   = 1'b1;
      m[s][w].tag = pc[31:12];
      m[s][w].tgt = tgt;
      m[s][w].ctr = 2;
    end
  endfunction

  // One clock: drive at negedge, predict from pre-edge model, check after edge
  task automatic cyc(input bit rst, input bit fl, input bit isb,
                     input bit [31:0] pc, input bit res,
                     input bit [31:0] ba, input bit tk,
                     input bit [31:0] tgt);
    bit        e_hit = 1'b0;
    bit        e_v   = 1'b0;
    bit [31:0] e_a   = '0;
    bit [1:0]  e_w   = '0;
    int        w;
    RESET                   = rst;
    Flush_IN                = fl;
    Is_Branch_IN            = isb;
    Instr_Addr_IN           = pc;
    Resolution_IN           = res;
    Branch_addr_IN          = ba;
    Branch_taken_IN         = tk;
    Branch_resolved_addr_IN = tgt;
    if (!rst && !fl && isb && m_find(pc, w)) begin
      e_hit = 1'b1;
      e_w   = 2'(w);
      if (m[int'(pc[11:2])][w].ctr >= 2) begin
        e_v = 1'b1;
        e_a = m[int'(pc[11:2])][w].tgt;
      end
    end
    if (rst || fl) m_clear();
    else if (res) m_update(ba, tk, tgt);
    @(posedge CLK);
    #1;
    chk("hit", 32'(Hit_OUT), 32'(e_hit));
    chk("way", 32'(Hit_Way_OUT), 32'(e_w));
    chk("valid", 32'(Valid_OUT), 32'(e_v));
    chk("addr", Addr_OUT, e_a);
    @(negedge CLK);
  endtask

  task automatic look(input bit [31:0] pc);
    cyc(0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic upd(input bit [31:0] pc, input bit tk,
                     input bit [31:0] tgt);
    cyc(0, 0, 0, 0, 1, pc, tk, tgt);
  endtask

  task automatic rst2();
    cyc(1, 0, 1, 32'h00400010, 1, 32'h00400010, 1, 32'h1234);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam bit [31:0] PA = 32'h00400010;
  localparam bit [31:0] PB = 32'h00401010;
  localparam bit [31:0] PC = 32'h00402010;
  localparam bit [31:0] PD = 32'h00403010;

  initial begin
    RESET = 1'b1; Flush_IN = 1'b0; Is_Branch_IN = 1'b0;
    Instr_Addr_IN = '0; Resolution_IN = 1'b0; Branch_addr_IN = '0;
    Branch_taken_IN = 1'b0; Branch_resolved_addr_IN = '0;
    m_clear();
    @(negedge CLK);
    rst2();
    look(PA);
    upd(PA, 1, 32'h00400100);
    look(PA);
    chk("dir_hit_addr", Addr_OUT, 32'h00400100);
    upd(PB, 1, 32'h00500000);
    upd(PC, 1, 32'h00600000);
    look(PA);
    look(PC);
    chk("dir_evict_way", 32'(Hit_Way_OUT), 32'd0);
    look(PB);
    chk("dir_way1", 32'(Hit_Way_OUT), 32'd1);

    rst2();
    upd(PA, 1, 32'h00700000);
    upd(PA, 0, 32'h0);
    upd(PA, 0, 32'h0);
    look(PA);
    upd(PA, 1, 32'h00700040);
    look(PA);
    upd(PA, 1, 32'h00700080);
    look(PA);

    rst2();
    cyc(0, 0, 1, PA, 1, PA, 1, 32'h00800000);
    look(PA);

    upd(PB, 1, 32'h00900000);
    cyc(0, 1, 1, PA, 1, PD, 1, 32'h00a00000);
    look(PA);
    look(PB);
    look(PD);

    cyc(0, 0, 1, PA, 0, 0, 0, 0);
    cyc(1, 0, 1, PA, 0, 0, 0, 0);
    look(PA);

    for (int n = 0; n < 3000; n++) begin
      bit [31:0] lp, bp;
      bit        r, f;
      lp = 32'h00400000 | ($urandom_range(0, 5) << 12)
         | ($urandom_range(4, 6) << 2);
      bp = 32'h00400000 | ($urandom_range(0, 5) << 12)
         | ($urandom_range(4, 6) << 2);
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 149) == 0);
      cyc(r, f, 1'($urandom_range(0, 3) != 0), lp,
          1'($urandom_range(0, 1)), bp, 1'($urandom_range(0, 2) != 0),
          $urandom() & 32'hfffffffc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2: associativity; legal values 1, 2, 4.
REQ-002 SHALL have parameter INDEX_BITS, default 10: sets = 2^INDEX_BITS; index = PC[INDEX_BITS+1:2].
REQ-003 SHALL derive TAG_BITS = 30-INDEX_BITS; tag = PC[31:INDEX_BITS+2].
REQ-004 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Flush_IN  input  1  invalidate all entries.
REQ-007 SHALL have port Instr_Addr_IN  input  32  lookup PC.
REQ-008 SHALL have port Is_Branch_IN  input  1  lookup request.
REQ-009 SHALL have port Resolution_IN  input  1  update request.
REQ-010 SHALL have port Branch_addr_IN  input  32  PC of resolved branch.
REQ-011 SHALL have port Branch_taken_IN  input  1  resolved direction.
REQ-012 SHALL have port Branch_resolved_addr_IN  input  32  resolved target.
REQ-013 SHALL have port Addr_OUT  output  32  predicted target, 0 when not predicted.
REQ-014 SHALL have port Valid_OUT  output  1  predict taken to Addr_OUT.
REQ-015 SHALL have port Hit_OUT  output  1  tag hit regardless of direction.
REQ-016 SHALL have port Hit_Way_OUT  output  2  way index of hit, 0 on miss.

Function
REQ-017 SHALL store per entry: valid, TAG_BITS tag, 32-bit target, 2-bit saturating counter; per set: victim pointer, width clog2(WAYS) (constant 0 when WAYS=1).
REQ-018 SHALL register lookup results: outputs reflect Instr_Addr_IN/Is_Branch_IN sampled at the previous edge (latency 1).
REQ-019 SHALL report hit when exactly one way has valid=1 and matching tag; Hit_OUT=1, Hit_Way_OUT=way.
REQ-020 SHALL drive Valid_OUT=1 and Addr_OUT=target only on hit with counter >= 2; otherwise Valid_OUT=0, Addr_OUT=0.
REQ-021 SHALL drive all outputs 0 in the cycle after a sample with Is_Branch_IN=0.
REQ-022 SHALL, on Resolution_IN=1 and hit in Branch_addr_IN's set: counter +1 (saturate 3) if taken, -1 (saturate 0) if not; target overwritten with Branch_resolved_addr_IN only if taken.
REQ-023 SHALL, on Resolution_IN=1, miss and taken: allocate entry with valid=1, tag, target, counter=2; on miss and not-taken: no change.
REQ-024 SHALL allocate into lowest-index invalid way; if none, into way = victim pointer, then pointer = (pointer+1) mod WAYS.
REQ-025 SHALL treat lookup and update as read-before-write: same-edge update to the looked-up set is invisible to that lookup, visible to the next.
REQ-026 SHALL give Flush_IN priority over Resolution_IN: flush clears all valid bits and victim pointers in one cycle; a lookup sampled on the flush edge reports miss.
REQ-027 SHALL leave target/tag/counter storage uninitialised; only valid bits and pointers are reset.

Reset
REQ-028 SHALL, while RESET=1, clear all valid bits, victim pointers, Addr_OUT, Valid_OUT, Hit_OUT, Hit_Way_OUT to 0 and ignore Resolution_IN and Is_Branch_IN.
REQ-029 SHALL, on reset asserted mid-operation, discard any pending lookup; first post-reset lookup result appears one cycle after its request.

Verification (WAYS=2, INDEX_BITS=10)
REQ-030 SHALL pass: reset, lookup 0x00400010 -> next cycle Hit_OUT=0, Valid_OUT=0, Addr_OUT=0.
REQ-031 SHALL pass: update 0x00400010 taken -> 0x00400100, then lookup -> Hit_OUT=1, Hit_Way_OUT=0, Valid_OUT=1, Addr_OUT=0x00400100.
REQ-032 SHALL pass: taken updates 0x00400010, 0x00401010, 0x00402010 (same index) -> ways 0,1, then way 0 evicted, pointer=1; lookup 0x00400010 misses, 0x00402010 hits way 0.
REQ-033 SHALL pass: hit entry counter 2, two not-taken updates -> counter 0; lookup -> Hit_OUT=1, Valid_OUT=0, Addr_OUT=0; one taken update -> counter 1, still Valid_OUT=0.
REQ-034 SHALL pass: update and lookup of 0x00400010 on same edge from empty -> that lookup misses; lookup next cycle hits.
REQ-035 SHALL pass: populated table, Flush_IN=1 with simultaneous taken update -> all subsequent lookups, including the updated PC, miss.
